// File: rtl/hicore_biu_arbt_pkg.sv
// ============================================================================
// Module      : hicore_biu_arbt_pkg
// Description : Shared definitions for the BIU command arbiter. Holds the ICB
//               field-width defaults, the requester index constants and a
//               small index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HiCore_ADDR_SIZE
`define HiCore_ADDR_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif

package hicore_biu_arbt_pkg;

    // ICB field widths
    localparam int HICORE_ICB_AW = `HiCore_ADDR_SIZE;
    localparam int HICORE_ICB_DW = `HiCore_REG_SIZE;

    // Requester ports in front of the BIU
    localparam int HICORE_ARBT_IFU = 0;
    localparam int HICORE_ARBT_LSU = 1;

    // Bits needed to index n items, never less than one
    function automatic int hicore_clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hicore_arbt_outs_fifo.sv
// ============================================================================
// Module      : hicore_arbt_outs_fifo
// Description : Outstanding-command FIFO. Stores the requester index of each
//               issued command so in-order responses can be routed back.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_push/i_push_data - enqueue a granted index
//               i_pop/o_pop_data   - dequeue / head index
//               o_full/o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hicore_arbt_outs_fifo
    import hicore_biu_arbt_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = hicore_clog2_min1(DEPTH);
    localparam int c_cnt_w = hicore_clog2_min1(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full     = (r_cnt == c_cnt_w'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;
    assign o_pop_data = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr <= (r_wptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hicore_biu_arbt.sv
// ============================================================================
// Module      : hicore_biu_arbt
// Description : N-to-1 ICB arbiter in front of the BIU command port. Picks one
//               requester per cycle, holds a stalled grant until it is
//               accepted, and routes in-order responses back through an
//               outstanding-index FIFO.
// Ports       : clk, rst_n         - clock, async active-low reset
//               i_bus_icb_cmd_*    - per-requester command channels (flattened)
//               i_bus_icb_rsp_*    - per-requester response channels
//               o_icb_cmd_*        - command channel to the BIU
//               o_icb_rsp_*        - response channel from the BIU
// Config      : HICORE_ARBT_RR_EN  - defined: round-robin arbitration;
//                                    undefined: fixed priority (port 0 highest)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HiCore_ADDR_SIZE
`define HiCore_ADDR_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif

module hicore_biu_arbt
    import hicore_biu_arbt_pkg::*;
#(
    parameter int ARB_NUM    = 2,
    parameter int AW         = `HiCore_ADDR_SIZE,
    parameter int DW         = `HiCore_REG_SIZE,
    parameter int OUTS_DEPTH = 2,
    parameter int IDX_W      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ARB_NUM-1:0]      i_bus_icb_cmd_valid,
    output logic [ARB_NUM-1:0]      i_bus_icb_cmd_ready,
    input  logic [ARB_NUM-1:0]      i_bus_icb_cmd_read,
    input  logic [ARB_NUM*AW-1:0]   i_bus_icb_cmd_addr,
    input  logic [ARB_NUM*DW-1:0]   i_bus_icb_cmd_wdata,
    input  logic [ARB_NUM*DW/8-1:0] i_bus_icb_cmd_wmask,
    output logic [ARB_NUM-1:0]      i_bus_icb_rsp_valid,
    input  logic [ARB_NUM-1:0]      i_bus_icb_rsp_ready,
    output logic [ARB_NUM-1:0]      i_bus_icb_rsp_err,
    output logic [ARB_NUM*DW-1:0]   i_bus_icb_rsp_rdata,
    output logic                    o_icb_cmd_valid,
    input  logic                    o_icb_cmd_ready,
    output logic                    o_icb_cmd_read,
    output logic [AW-1:0]           o_icb_cmd_addr,
    output logic [DW-1:0]           o_icb_cmd_wdata,
    output logic [DW/8-1:0]         o_icb_cmd_wmask,
    input  logic                    o_icb_rsp_valid,
    output logic                    o_icb_rsp_ready,
    input  logic                    o_icb_rsp_err,
    input  logic [DW-1:0]           o_icb_rsp_rdata
);

    localparam int c_mw = DW / 8;

    // Grant-hold state: ARB lets the arbiter choose, HOLD pins the grant
    // on a command the BIU has not yet accepted.
    localparam logic [0:0] c_st_arb  = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_arb_idx;
    logic [IDX_W-1:0] w_grant_idx;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_req_valid;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_cmd_hsk;
    logic             w_stall;
    logic             w_rsp_hsk;

    // ------------------------------------------------------------------
    // Arbitration winner
    // ------------------------------------------------------------------
`ifdef HICORE_ARBT_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;

    always_comb begin
        logic v_found;
        int   v_j;
        w_arb_idx = '0;
        v_found   = 1'b0;
        v_j       = 0;
        // First valid port at or above the pointer, wrapping past the top
        for (int i = 0; i < ARB_NUM; i++) begin
            v_j = int'(r_rr_ptr) + i;
            if (v_j >= ARB_NUM) begin
                v_j = v_j - ARB_NUM;
            end
            if (!v_found && i_bus_icb_cmd_valid[v_j]) begin
                v_found   = 1'b1;
                w_arb_idx = IDX_W'(v_j);
            end
        end
    end

    // Only a freshly arbitrated handshake moves the pointer; completing a
    // held command leaves the rotation where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_cmd_hsk && !w_lock) begin
            r_rr_ptr <= (w_grant_idx == IDX_W'(ARB_NUM - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        w_arb_idx = '0;
        // Scan downward so the lowest valid index is the last to win
        for (int i = ARB_NUM - 1; i >= 0; i--) begin
            if (i_bus_icb_cmd_valid[i]) begin
                w_arb_idx = IDX_W'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Command path (combinational, no added latency)
    // ------------------------------------------------------------------
    assign w_grant_idx     = w_lock ? r_lock_idx : w_arb_idx;
    assign w_req_valid     = i_bus_icb_cmd_valid[w_grant_idx];
    assign o_icb_cmd_valid = w_req_valid & ~w_fifo_full;
    assign o_icb_cmd_read  = i_bus_icb_cmd_read[w_grant_idx];
    assign o_icb_cmd_addr  = i_bus_icb_cmd_addr[int'(w_grant_idx)*AW +: AW];
    assign o_icb_cmd_wdata = i_bus_icb_cmd_wdata[int'(w_grant_idx)*DW +: DW];
    assign o_icb_cmd_wmask = i_bus_icb_cmd_wmask[int'(w_grant_idx)*c_mw +: c_mw];
    assign w_cmd_hsk       = o_icb_cmd_valid & o_icb_cmd_ready;
    assign w_stall         = o_icb_cmd_valid & ~o_icb_cmd_ready;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    assign o_icb_rsp_ready     = i_bus_icb_rsp_ready[w_head_idx] & ~w_fifo_empty;
    assign w_rsp_hsk           = o_icb_rsp_valid & o_icb_rsp_ready;
    assign i_bus_icb_rsp_err   = {ARB_NUM{o_icb_rsp_err}};
    assign i_bus_icb_rsp_rdata = {ARB_NUM{o_icb_rsp_rdata}};

    // Ready is only offered to the granted port while it is actually
    // requesting, so an idle arbiter shows no ready anywhere.
    for (genvar k = 0; k < ARB_NUM; k++) begin : g_port
        assign i_bus_icb_cmd_ready[k] = (w_grant_idx == IDX_W'(k)) & w_req_valid
                                        & o_icb_cmd_ready & ~w_fifo_full;
        assign i_bus_icb_rsp_valid[k] = (w_head_idx == IDX_W'(k)) & o_icb_rsp_valid
                                        & ~w_fifo_empty;
    end

    // ------------------------------------------------------------------
    // Grant-hold FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_arb;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_arb:  if (w_stall)   w_state_nxt = c_st_hold;
            c_st_hold: if (w_cmd_hsk) w_state_nxt = c_st_arb;
            default:                  w_state_nxt = c_st_arb;
        endcase
    end

    always_comb begin
        w_lock = (r_state == c_st_hold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_idx <= '0;
        end else if (w_stall) begin
            r_lock_idx <= w_grant_idx;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding index FIFO
    // ------------------------------------------------------------------
    hicore_arbt_outs_fifo #(
        .DEPTH (OUTS_DEPTH),
        .WIDTH (IDX_W)
    ) u_outs_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_cmd_hsk),
        .i_push_data (w_grant_idx),
        .i_pop       (w_rsp_hsk),
        .o_pop_data  (w_head_idx),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_hicore_biu_arbt.sv
// ============================================================================
// Module      : tb_hicore_biu_arbt
// Description : Self-checking bench for hicore_biu_arbt (2 ports, depth 2).
//               Table vectors, directed corner sequences and a random phase,
//               all checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hicore_biu_arbt;

    localparam int N     = 2;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  v;
    logic [1:0]  rd;
    logic [31:0] addr_in  [2];
    logic [31:0] wdata_in [2];
    logic [3:0]  wmask_in [2];
    logic [1:0]  rr;
    logic        brdy;
    logic        biu_rv;
    logic        biu_err;
    logic [31:0] biu_rdata;

    logic [63:0] cmd_addr_f;
    logic [63:0] cmd_wdata_f;
    logic [7:0]  cmd_wmask_f;
    logic [1:0]  cmd_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [63:0] rsp_rdata;
    logic        cmd_valid;
    logic        cmd_read;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_ready_o;

    assign cmd_addr_f  = {addr_in[1], addr_in[0]};
    assign cmd_wdata_f = {wdata_in[1], wdata_in[0]};
    assign cmd_wmask_f = {wmask_in[1], wmask_in[0]};

    hicore_biu_arbt dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_bus_icb_cmd_valid (v),
        .i_bus_icb_cmd_ready (cmd_ready),
        .i_bus_icb_cmd_read  (rd),
        .i_bus_icb_cmd_addr  (cmd_addr_f),
        .i_bus_icb_cmd_wdata (cmd_wdata_f),
        .i_bus_icb_cmd_wmask (cmd_wmask_f),
        .i_bus_icb_rsp_valid (rsp_valid),
        .i_bus_icb_rsp_ready (rr),
        .i_bus_icb_rsp_err   (rsp_err),
        .i_bus_icb_rsp_rdata (rsp_rdata),
        .o_icb_cmd_valid     (cmd_valid),
        .o_icb_cmd_ready     (brdy),
        .o_icb_cmd_read      (cmd_read),
        .o_icb_cmd_addr      (cmd_addr),
        .o_icb_cmd_wdata     (cmd_wdata),
        .o_icb_cmd_wmask     (cmd_wmask),
        .o_icb_rsp_valid     (biu_rv),
        .o_icb_rsp_ready     (rsp_ready_o),
        .o_icb_rsp_err       (biu_err),
        .o_icb_rsp_rdata     (biu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of requester ids awaiting a response, the port
    // whose command is pinned by a stall (-1 if none), and the RR pointer.
    int q[$];
    int held = -1;
    int ptr  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mwin(input logic [1:0] vv);
`ifdef HICORE_ARBT_RR_EN
        for (int i = 0; i < N; i++) begin
            if (vv[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
`else
        for (int i = 0; i < N; i++) begin
            if (vv[i]) return i;
        end
        return 0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        held = -1;
        ptr  = 0;
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic step();
        bit   full, empty, e_cv, e_ordy, chs, rhs;
        int   g, h;
        logic [1:0] e_crdy, e_rv;
        full  = (q.size() >= DEPTH);
        empty = (q.size() == 0);
        g     = (held >= 0) ? held : mwin(v);
        h     = empty ? 0 : q[0];
        e_cv  = v[g] && !full;
        e_crdy = (e_cv && brdy) ? 2'(1 << g) : 2'b00;
        e_rv   = (!empty && biu_rv) ? 2'(1 << h) : 2'b00;
        e_ordy = !empty && rr[h];
        chk("cmd_valid", 64'(cmd_valid), 64'(e_cv));
        chk("cmd_ready", 64'(cmd_ready), 64'(e_crdy));
        chk("cmd_addr", 64'(cmd_addr), 64'(addr_in[g]));
        chk("cmd_read", 64'(cmd_read), 64'(rd[g]));
        chk("cmd_wdata", 64'(cmd_wdata), 64'(wdata_in[g]));
        chk("cmd_wmask", 64'(cmd_wmask), 64'(wmask_in[g]));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        chk("rsp_ready", 64'(rsp_ready_o), 64'(e_ordy));
        chk("rsp_err", 64'(rsp_err), 64'({2{biu_err}}));
        chk("rsp_rdata", rsp_rdata, {biu_rdata, biu_rdata});
        chs = e_cv && brdy;
        rhs = biu_rv && e_ordy;
        @(posedge clk);
        if (rhs) void'(q.pop_front());
        if (chs) begin
            q.push_back(g);
            if (held < 0) ptr = (g + 1) % N;
            held = -1;
        end else if (e_cv) begin
            held = g;
        end
        #1;
    endtask

    task automatic cyc();
        #3;
        step();
    endtask

    task automatic idle_inputs();
        v = 2'b00; brdy = 1'b1; biu_rv = 1'b0; rr = 2'b11;
        biu_err = 1'b0; biu_rdata = 32'h0;
    endtask

    task automatic drain();
        idle_inputs();
        biu_rv = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: outstanding %0d expected 0", q.size());
        end
        biu_rv = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic        brdy;
        logic        rv;
        logic [1:0]  rr;
        logic [31:0] rdata;
        logic        e_cv;
        logic [31:0] e_addr;
        logic [1:0]  e_crdy;
        logic [1:0]  e_rv;
        logic        e_ordy;
    } vec_t;

    vec_t tbl[8];
    int   eg[3];

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        addr_in[0]  = 32'h8000_0000; addr_in[1]  = 32'h2000_0000;
        wdata_in[0] = 32'h1111_0000; wdata_in[1] = 32'h1111_0001;
        wmask_in[0] = 4'b0011;       wmask_in[1] = 4'b1111;
        rd = 2'b11;
        idle_inputs();
        rst_n = 1'b0;

        // Sequence of cycles from reset; no cycle has both ports competing
        // unlocked, so both arbitration modes expect the same results.
        tbl[0] = '{2'b00, 1'b1, 1'b0, 2'b11, 32'h0,         1'b0, 32'h8000_0000, 2'b00, 2'b00, 1'b0};
        tbl[1] = '{2'b10, 1'b1, 1'b0, 2'b11, 32'h0,         1'b1, 32'h2000_0000, 2'b10, 2'b00, 1'b0};
        tbl[2] = '{2'b01, 1'b1, 1'b1, 2'b11, 32'h1234_5678, 1'b1, 32'h8000_0000, 2'b01, 2'b10, 1'b1};
        tbl[3] = '{2'b00, 1'b1, 1'b1, 2'b10, 32'h0000_0055, 1'b0, 32'h0,         2'b00, 2'b01, 1'b0};
        tbl[4] = '{2'b00, 1'b1, 1'b1, 2'b01, 32'h0000_0066, 1'b0, 32'h0,         2'b00, 2'b01, 1'b1};
        tbl[5] = '{2'b00, 1'b1, 1'b1, 2'b11, 32'h0000_0077, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0};
        tbl[6] = '{2'b01, 1'b0, 1'b0, 2'b11, 32'h0,         1'b1, 32'h8000_0000, 2'b00, 2'b00, 1'b0};
        tbl[7] = '{2'b01, 1'b1, 1'b0, 2'b11, 32'h0,         1'b1, 32'h8000_0000, 2'b01, 2'b00, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = tbl[i].v; brdy = tbl[i].brdy; biu_rv = tbl[i].rv;
            rr = tbl[i].rr; biu_rdata = tbl[i].rdata;
            #3;
            chk("tbl_cmd_valid", 64'(cmd_valid), 64'(tbl[i].e_cv));
            chk("tbl_cmd_ready", 64'(cmd_ready), 64'(tbl[i].e_crdy));
            chk("tbl_rsp_valid", 64'(rsp_valid), 64'(tbl[i].e_rv));
            chk("tbl_rsp_ready", 64'(rsp_ready_o), 64'(tbl[i].e_ordy));
            if (tbl[i].e_cv) chk("tbl_cmd_addr", 64'(cmd_addr), 64'(tbl[i].e_addr));
            step();
        end
        drain();

        // Both ports requesting every cycle from reset
`ifdef HICORE_ARBT_RR_EN
        eg = '{0, 1, 0};
`else
        eg = '{0, 0, 0};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v = 2'b11; brdy = 1'b1; rr = 2'b11;
            biu_rv = (i > 0);
            #3;
            chk("arb_order_addr", 64'(cmd_addr), 64'(addr_in[eg[i]]));
            chk("arb_order_ready", 64'(cmd_ready), 64'(2'(1 << eg[i])));
            step();
        end
        drain();

        // Stalled port1 command is not preempted by port0
        v = 2'b10; brdy = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            v = 2'b11; brdy = 1'b0;
            #3;
            chk("lock_addr", 64'(cmd_addr), 64'h2000_0000);
            step();
        end
        v = 2'b11; brdy = 1'b1;
        #3;
        chk("lock_hsk_ready", 64'(cmd_ready), 64'b10);
        step();
        v = 2'b01;
        #3;
        chk("after_lock_addr", 64'(cmd_addr), 64'h8000_0000);
        step();
        drain();

        // Outstanding FIFO full blocks the third command
        v = 2'b01; brdy = 1'b1; cyc();
        v = 2'b10; cyc();
        v = 2'b01;
        #3;
        chk("full_cmd_valid", 64'(cmd_valid), 64'b0);
        chk("full_cmd_ready", 64'(cmd_ready), 64'b00);
        step();
        biu_rv = 1'b1; biu_rdata = 32'hDEAD_BEEF; rr = 2'b11;
        #3;
        chk("full_pop_cmd_ready", 64'(cmd_ready), 64'b00);
        chk("full_rsp_valid", 64'(rsp_valid), 64'b01);
        chk("full_rsp_rdata", rsp_rdata[31:0], 64'hDEAD_BEEF);
        step();
        biu_rv = 1'b0; rd[0] = 1'b0;
        #3;
        chk("freed_cmd_ready", 64'(cmd_ready), 64'b01);
        chk("freed_wmask", 64'(cmd_wmask), 64'b0011);
        step();
        rd[0] = 1'b1;

        // Head response for port1 stalled by its rsp_ready
        v = 2'b00; biu_rv = 1'b1; biu_rdata = 32'hCAFE_F00D; rr = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("bp_rsp_ready", 64'(rsp_ready_o), 64'b0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'b10);
            chk("bp_rdata", rsp_rdata[63:32], 64'hCAFE_F00D);
            step();
        end
        rr = 2'b11; cyc();

        // Error response to the port0 write, then FIFO is empty
        biu_err = 1'b1;
        #3;
        chk("err_port0", 64'(rsp_err[0]), 64'b1);
        chk("err_rsp_ready", 64'(rsp_ready_o), 64'b1);
        step();
        biu_err = 1'b0;
        #3;
        chk("empty_rsp_ready", 64'(rsp_ready_o), 64'b0);
        chk("empty_rsp_valid", 64'(rsp_valid), 64'b00);
        step();
        idle_inputs();

        // Reset with two outstanding, then with one outstanding and a lock
        for (int pass = 0; pass < 2; pass++) begin
            v = 2'b10; brdy = 1'b1; cyc();
            v = (pass == 0) ? 2'b01 : 2'b10; brdy = (pass == 0);
            cyc();
            rst_n = 1'b0;
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            v = 2'b11; brdy = 1'b1; biu_rv = 1'b1; rr = 2'b11;
            #3;
            chk("rst_rsp_ready", 64'(rsp_ready_o), 64'b0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'b00);
            chk("rst_grant_addr", 64'(cmd_addr), 64'h8000_0000);
            step();
            drain();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            v = 2'($urandom);
            if (held >= 0) v[held] = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (held != k) addr_in[k] = $urandom;
                wdata_in[k] = $urandom;
                wmask_in[k] = 4'($urandom);
            end
            rd = 2'($urandom);
            brdy = ($urandom_range(0, 2) != 0);
            biu_rv = (q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            biu_err = ($urandom_range(0, 5) == 0);
            biu_rdata = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hicore_biu_arbt.md
Name:
hicore_biu_arbt

Overview:
- N-to-1 ICB arbiter in front of the BIU command port; shares the BIU between the core requesters (IFU fetch at port 0, LSU at port 1).
- Selects one command per cycle, holds the grant while the BIU back-pressures, and records the granted index in an outstanding FIFO.
- Routes each in-order BIU response back to the requester that issued the command.

Parameters:
- ARB_NUM, 2, number of requester ports.
- AW, 32, address width (`HiCore_ADDR_SIZE).
- DW, 32, data width (`HiCore_REG_SIZE).
- OUTS_DEPTH, 2, maximum outstanding commands not yet answered (1..8).
- IDX_W, 1, requester index width (clog2 of ARB_NUM, minimum 1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_bus_icb_cmd_valid  in  ARB_NUM  per-requester command valid
- i_bus_icb_cmd_ready  out  ARB_NUM  per-requester command ready
- i_bus_icb_cmd_read  in  ARB_NUM  read=1/write=0
- i_bus_icb_cmd_addr  in  ARB_NUM*AW  flattened; port k at [k*AW +: AW]
- i_bus_icb_cmd_wdata  in  ARB_NUM*DW  flattened write data
- i_bus_icb_cmd_wmask  in  ARB_NUM*DW/8  flattened byte mask
- i_bus_icb_rsp_valid  out  ARB_NUM  per-requester response valid
- i_bus_icb_rsp_ready  in  ARB_NUM  per-requester response ready
- i_bus_icb_rsp_err  out  ARB_NUM  response error
- i_bus_icb_rsp_rdata  out  ARB_NUM*DW  flattened read data (broadcast)
- o_icb_cmd_valid/ready/read/addr/wdata/wmask  out/in/out/out/out/out  1/1/1/AW/DW/DW/8  to BIU command
- o_icb_rsp_valid/ready/err/rdata  in/out/in/in  1/1/1/DW  from BIU response

Behaviour:
- Reset state: outstanding FIFO empty, lock flag 0, lock index 0, round-robin pointer 0.
  - With all request valids low: o_icb_cmd_valid=0, all i_bus_icb_cmd_ready=0, all i_bus_icb_rsp_valid=0, o_icb_rsp_ready=0.
- Command path is combinational; zero added latency.
  - Grant index g is the lock index if lock=1, otherwise the arbitration winner.
  - o_icb_cmd_valid = i_bus_icb_cmd_valid[g] & ~fifo_full; o_icb_cmd_* payload = port g fields.
  - i_bus_icb_cmd_ready[k] = (k==g) & o_icb_cmd_ready & ~fifo_full.
- Lock: when o_icb_cmd_valid=1 and o_icb_cmd_ready=0, set lock=1 and lock index=g. Cleared on the next cmd handshake. A higher-priority request never preempts a stalled command.
- Command handshake pushes g into the FIFO.
- Response path:
  - Head index h = FIFO head.
  - i_bus_icb_rsp_valid[h] = o_icb_rsp_valid & ~fifo_empty; other ports 0.
  - o_icb_rsp_ready = i_bus_icb_rsp_ready[h] & ~fifo_empty.
  - err and rdata are forwarded unchanged.
  - Response handshake pops the FIFO.
- FIFO full: all cmd ready and o_icb_cmd_valid forced 0, even if a pop happens in the same cycle (no cut-through; the slot frees next cycle).
- Push and pop in the same cycle (not full): count unchanged; pointers both advance and wrap modulo OUTS_DEPTH.
- Response with FIFO empty: treated as a protocol violation. o_icb_rsp_ready=0 and nothing is routed.
- The BIU returns responses in order. Response no earlier than one cycle after its command handshake.
- Reset mid-transaction discards the FIFO and lock. Responses for in-flight commands are dropped; the BIU is reset by the same rst_n.

Optional Feature:
- HICORE_ARBT_RR_EN defined: round-robin arbitration.
  - Winner is the first valid port at or after the pointer, searching upward with wrap.
  - On each unlocked cmd handshake the pointer becomes (g+1) mod ARB_NUM.
- Undefined: fixed priority, lowest index wins (port 0 = IFU highest). The pointer register is not instantiated.

Decomposition:
- Shared package/defines: ICB field widths (reuse `HiCore_ADDR_SIZE/`HiCore_REG_SIZE), requester index constants (HICORE_ARBT_IFU=0, HICORE_ARBT_LSU=1).
- Sub-module hicore_arbt_outs_fifo: IDX_W-wide, OUTS_DEPTH-entry synchronous FIFO with full/empty flags, async active-low reset.

Test Plan:
- Reset; port0 and port1 both valid, addr 0x8000_0000/0x2000_0000, BIU ready=1 -> fixed mode grants port0 first. RR mode alternates 0,1,0 over three cycles.
- Port1 granted, BIU ready=0 for 3 cycles while port0 raises valid -> o_icb_cmd_addr stays 0x2000_0000 until handshake, then port0 issues.
- OUTS_DEPTH=2: issue port0, port1 with no responses -> third command blocked (all cmd ready=0). A response to port0 with rdata 0xDEAD_BEEF appears only on i_bus_icb_rsp_valid[0]; the third command proceeds the next cycle.
- Port1 rsp_ready=0 while the head response is for port1 -> o_icb_rsp_ready=0, rdata held, port0 receives no valid.
- Response with rsp_err=1 for port0 write (wmask 4'b0011) -> i_bus_icb_rsp_err[0]=1, FIFO pops, count decrements.
- Assert rst_n low with 2 outstanding -> next cycle FIFO empty, lock=0, o_icb_rsp_ready=0.
